sram_column_buffer: RTL and testbench

- Manages the single-port boundary-column SRAM as a circular FIFO for the PE array controller.
- Words written at the end of one pass (last-PE H/F column) are read back in order during the next pass.
- Generates all SRAM addresses and enables, and arbitrates reads against writes on the one SRAM port.
- Sits between the PE array controller's read/write strobes and the SRAM macro.

---
 rtl/sram_column_buffer_pkg.sv | 13 +
 rtl/sram_column_buffer_if.sv | 26 ++
 rtl/sram_column_buffer.sv | 128 ++++++++++++
 tb/tb_sram_column_buffer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_column_buffer_pkg.sv
// Shared widths and the port-grant type for the boundary-column SRAM FIFO.
package sram_column_buffer_pkg;

  localparam int SRAM_WORD        = 32;
  localparam int ADDR_BIT_DEFAULT = 10;

  typedef enum logic [1:0] {
    GRANT_NONE  = 2'd0,
    GRANT_READ  = 2'd1,
    GRANT_WRITE = 2'd2
  } grant_e;

endpackage

// File: rtl/sram_column_buffer_if.sv
// PE-controller side handshake of the column buffer: write strobe/data, read strobe/data.
interface sram_column_buffer_if
  import sram_column_buffer_pkg::*;
#(
  parameter int WORD = SRAM_WORD
);

  logic            i_write;
  logic [WORD-1:0] i_writeData;
  logic            o_write_ready;
  logic            i_read;
  logic            o_read_ready;
  logic [WORD-1:0] o_readData;
  logic            o_readValid;

  modport master (
    output i_write, i_writeData, i_read,
    input  o_write_ready, o_read_ready, o_readData, o_readValid
  );

  modport slave (
    input  i_write, i_writeData, i_read,
    output o_write_ready, o_read_ready, o_readData, o_readValid
  );

endinterface

// File: rtl/sram_column_buffer.sv
// Circular FIFO over a single-port SRAM: one-entry write buffer, read-priority
// arbitration with a one-cycle starvation limit for the buffered write.
module sram_column_buffer
  import sram_column_buffer_pkg::*;
#(
  parameter int WORD     = SRAM_WORD,
  parameter int ADDR_BIT = ADDR_BIT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_clear,
  sram_column_buffer_if.slave pe,
  output logic                o_sram_cen,
  output logic                o_sram_wen,
  output logic [ADDR_BIT-1:0] o_sram_addr,
  output logic [WORD-1:0]     o_sram_wdata,
  input  logic [WORD-1:0]     i_sram_rdata,
  output logic [ADDR_BIT:0]   o_count,
  output logic                o_empty,
  output logic                o_full
);

  localparam logic [ADDR_BIT:0] DEPTH = {1'b1, {ADDR_BIT{1'b0}}};

  logic [ADDR_BIT-1:0] wptr;
  logic [ADDR_BIT-1:0] rptr;
  logic [ADDR_BIT:0]   count;
  logic [ADDR_BIT:0]   committed;
  logic [WORD-1:0]     wbuf;
  logic                wbuf_valid;
  logic                wbuf_age;
  logic                rd_pend;
  logic                write_ready;
  logic                read_ready;
  logic                wr_acc;
  logic                rd_acc;
  grant_e              grant;

  // rst_n gates write_ready so every handshake output is low while held in reset
  assign write_ready = rst_n && !i_clear && !wbuf_valid && (count < DEPTH);
  assign read_ready  = !i_clear && (committed != '0) && !(wbuf_valid && wbuf_age);
  assign wr_acc      = pe.i_write && write_ready;
  assign rd_acc      = pe.i_read && read_ready;

  assign pe.o_write_ready = write_ready;
  assign pe.o_read_ready  = read_ready;
  assign o_count          = count;
  assign o_empty          = (count == '0);
  assign o_full           = (count == DEPTH);

  always_comb begin
    grant = GRANT_NONE;
    if (rd_acc)
      grant = GRANT_READ;
    else if (wbuf_valid && !i_clear)
      grant = GRANT_WRITE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr           <= '0;
      rptr           <= '0;
      count          <= '0;
      committed      <= '0;
      wbuf           <= '0;
      wbuf_valid     <= 1'b0;
      wbuf_age       <= 1'b0;
      rd_pend        <= 1'b0;
      o_sram_cen     <= 1'b0;
      o_sram_wen     <= 1'b0;
      o_sram_addr    <= '0;
      o_sram_wdata   <= '0;
      pe.o_readData  <= '0;
      pe.o_readValid <= 1'b0;
    end else if (i_clear) begin
      wptr           <= '0;
      rptr           <= '0;
      count          <= '0;
      committed      <= '0;
      wbuf_valid     <= 1'b0;
      wbuf_age       <= 1'b0;
      rd_pend        <= 1'b0;
      o_sram_cen     <= 1'b0;
      pe.o_readValid <= 1'b0;
    end else begin
      rd_pend        <= rd_acc;
      pe.o_readValid <= rd_pend;
      if (rd_pend)
        pe.o_readData <= i_sram_rdata;

      unique case (grant)
        GRANT_READ: begin
          o_sram_cen  <= 1'b1;
          o_sram_wen  <= 1'b0;
          o_sram_addr <= rptr;
          rptr        <= rptr + ADDR_BIT'(1);
          committed   <= committed - (ADDR_BIT+1)'(1);
          // buffered write lost this cycle; read_ready is held off next cycle
          if (wbuf_valid)
            wbuf_age <= 1'b1;
        end
        GRANT_WRITE: begin
          o_sram_cen   <= 1'b1;
          o_sram_wen   <= 1'b1;
          o_sram_addr  <= wptr;
          o_sram_wdata <= wbuf;
          wptr         <= wptr + ADDR_BIT'(1);
          committed    <= committed + (ADDR_BIT+1)'(1);
          wbuf_valid   <= 1'b0;
          wbuf_age     <= 1'b0;
        end
        default: o_sram_cen <= 1'b0;
      endcase

      if (wr_acc) begin
        wbuf       <= pe.i_writeData;
        wbuf_valid <= 1'b1;
        wbuf_age   <= 1'b0;
      end

      if (wr_acc && !rd_acc)
        count <= count + (ADDR_BIT+1)'(1);
      else if (rd_acc && !wr_acc)
        count <= count - (ADDR_BIT+1)'(1);
    end
  end

endmodule

// File: tb/tb_sram_column_buffer.sv
// Directed + random bench for sram_column_buffer with a queue-based reference model.
module tb_sram_column_buffer;

  localparam int WORD     = 8;
  localparam int ADDR_BIT = 2;
  localparam int DEPTH    = 4;

  logic                clk;
  logic                rst_n;
  logic                i_clear;
  logic                o_sram_cen;
  logic                o_sram_wen;
  logic [ADDR_BIT-1:0] o_sram_addr;
  logic [WORD-1:0]     o_sram_wdata;
  logic [WORD-1:0]     i_sram_rdata;
  logic [ADDR_BIT:0]   o_count;
  logic                o_empty;
  logic                o_full;

  sram_column_buffer_if #(.WORD(WORD)) pe_if ();

  sram_column_buffer #(.WORD(WORD), .ADDR_BIT(ADDR_BIT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (i_clear),
    .pe           (pe_if),
    .o_sram_cen   (o_sram_cen),
    .o_sram_wen   (o_sram_wen),
    .o_sram_addr  (o_sram_addr),
    .o_sram_wdata (o_sram_wdata),
    .i_sram_rdata (i_sram_rdata),
    .o_count      (o_count),
    .o_empty      (o_empty),
    .o_full       (o_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM macro: write on the clock edge, read data of the presented address
  logic [WORD-1:0] mem [DEPTH];
  always @(posedge clk) if (o_sram_cen && o_sram_wen) mem[o_sram_addr] <= o_sram_wdata;
  assign i_sram_rdata = mem[o_sram_addr];

  int checks   = 0;
  int failures = 0;

  // reference model: every word held, oldest first (buffered word is the newest)
  logic [WORD-1:0]     held_q [$];
  int                  committed_m;
  bit                  pend_v, waited;
  logic [WORD-1:0]     pend_d;
  logic [ADDR_BIT-1:0] next_waddr, next_raddr;
  bit                  pipe1;
  logic [WORD-1:0]     pipe1_d;
  bit                  exp_rv;
  logic [WORD-1:0]     exp_rd;
  bit                  exp_cen, exp_wen;
  logic [ADDR_BIT-1:0] exp_addr;
  logic [WORD-1:0]     exp_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    held_q.delete();
    committed_m = 0;
    pend_v = 0; waited = 0; pipe1 = 0; exp_rv = 0; exp_cen = 0;
    next_waddr = '0; next_raddr = '0;
  endtask

  task automatic check_outputs();
    chk("count", 32'(o_count), 32'(held_q.size()));
    chk("empty", 32'(o_empty), 32'(held_q.size() == 0));
    chk("full", 32'(o_full), 32'(held_q.size() == DEPTH));
    chk("sram_cen", 32'(o_sram_cen), 32'(exp_cen));
    if (exp_cen) begin
      chk("sram_wen", 32'(o_sram_wen), 32'(exp_wen));
      chk("sram_addr", 32'(o_sram_addr), 32'(exp_addr));
      if (exp_wen) chk("sram_wdata", 32'(o_sram_wdata), 32'(exp_wdata));
    end
    chk("read_valid", 32'(pe_if.o_readValid), 32'(exp_rv));
    if (exp_rv) chk("read_data", 32'(pe_if.o_readData), 32'(exp_rd));
  endtask

  task automatic cycle(input bit w, input logic [WORD-1:0] d, input bit r, input bit clr,
                       output bit wacc);
    bit m_wr, m_rr, racc;
    pe_if.i_write = w; pe_if.i_writeData = d; pe_if.i_read = r; i_clear = clr;
    m_wr = !clr && !pend_v && (held_q.size() < DEPTH);
    m_rr = !clr && (committed_m > 0) && !(pend_v && waited);
    #1;
    chk("write_ready", 32'(pe_if.o_write_ready), 32'(m_wr));
    chk("read_ready", 32'(pe_if.o_read_ready), 32'(m_rr));
    wacc = w && m_wr;
    racc = r && m_rr;
    @(posedge clk);
    if (clr) begin
      reset_model();
    end else begin
      exp_rv  = pipe1;
      exp_rd  = pipe1_d;
      pipe1   = racc;
      exp_cen = 0;
      if (racc) begin
        pipe1_d = held_q.pop_front();
        exp_cen = 1; exp_wen = 0; exp_addr = next_raddr;
        next_raddr++;
        committed_m--;
        if (pend_v) waited = 1;
      end else if (pend_v) begin
        exp_cen = 1; exp_wen = 1; exp_addr = next_waddr; exp_wdata = pend_d;
        next_waddr++;
        committed_m++;
        pend_v = 0; waited = 0;
      end
      if (wacc) begin
        held_q.push_back(d);
        pend_v = 1; pend_d = d; waited = 0;
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cycle(0, '0, 0, 0, a);
  endtask

  task automatic push(input logic [WORD-1:0] d);
    bit a;
    a = 0;
    for (int i = 0; i < 10 && !a; i++) cycle(1, d, 0, 0, a);
    chk("push_bound", 32'(a), 32'(1));
  endtask

  task automatic drain();
    bit a;
    int n;
    n = 0;
    while ((held_q.size() != 0 || pipe1 || exp_rv) && n < 40) begin
      cycle(0, '0, 1, 0, a);
      n++;
    end
    chk("drain_bound", 32'(held_q.size()), 32'(0));
    idle(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_count"}, 32'(o_count), 32'(0));
    chk({tag, "_empty"}, 32'(o_empty), 32'(1));
    chk({tag, "_full"}, 32'(o_full), 32'(0));
    chk({tag, "_wready"}, 32'(pe_if.o_write_ready), 32'(0));
    chk({tag, "_rready"}, 32'(pe_if.o_read_ready), 32'(0));
    chk({tag, "_rvalid"}, 32'(pe_if.o_readValid), 32'(0));
    chk({tag, "_rdata"}, 32'(pe_if.o_readData), 32'(0));
    chk({tag, "_cen"}, 32'(o_sram_cen), 32'(0));
    chk({tag, "_wen"}, 32'(o_sram_wen), 32'(0));
    chk({tag, "_addr"}, 32'(o_sram_addr), 32'(0));
    chk({tag, "_wdata"}, 32'(o_sram_wdata), 32'(0));
  endtask

  initial begin
    bit a;
    logic [WORD-1:0] cur;
    rst_n = 1'b0; i_clear = 1'b0;
    pe_if.i_write = 1'b0; pe_if.i_writeData = '0; pe_if.i_read = 1'b0;
    reset_model();
    #3;
    check_reset_outputs("reset");
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    idle(1);

    // three writes, then fill to four and hold a fifth until a read frees a slot
    push(8'h0A); push(8'h0B); push(8'h0C);
    idle(2);
    push(8'h0D);
    idle(1);
    chk("full_flag", 32'(o_full), 32'(1));
    for (int i = 0; i < 3; i++) cycle(1, 8'h0E, 0, 0, a);
    cycle(1, 8'h0E, 1, 0, a);
    push(8'h0E);
    drain();

    // concurrent read+write every cycle with two entries preloaded
    push(8'h21); push(8'h22);
    idle(1);
    cur = 8'h30;
    for (int i = 0; i < 14; i++) begin
      cycle(1, cur, 1, 0, a);
      if (a) cur = cur + 8'h01;
    end
    drain();

    // clear one cycle after a read accept cancels the pending data
    push(8'h55); push(8'h66);
    idle(2);
    cycle(0, '0, 1, 0, a);
    cycle(0, '0, 0, 1, a);
    idle(3);
    push(8'h77);
    drain();

    // random traffic with held requests and occasional clears
    cur = 8'($urandom);
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 3) != 0, cur, ($urandom % 2) == 0, ($urandom % 50) == 0, a);
      if (a) cur = 8'($urandom);
    end
    drain();

    // asynchronous reset in the middle of traffic
    push(8'h91); push(8'h92);
    idle(1);
    cycle(1, 8'h93, 1, 0, a);
    pe_if.i_write = 1'b0; pe_if.i_read = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    reset_model();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    idle(2);
    push(8'hA5);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
